// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS instruction-fetch front end: fetch FSM states,
// PC stride and the (pc, instr) queue entry.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INCR    = 4;
    localparam int unsigned ENTRY_PC_W = 32;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_fifo.sv
// Registered FIFO of fetch entries with flush; head is read straight from
// storage, so a push becomes visible on the following cycle.
module mips_fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_flush,
    input  logic               i_push,
    input  fetch_entry_t       i_push_data,
    input  logic               i_pop,
    output fetch_entry_t       o_head,
    output logic [CNT_W-1:0]   o_count
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mips_fetch_queue.sv
// MIPS fetch front end: sequential fetch FSM, one request in flight, queue of
// (pc, instr) to the core, redirect flush. Optional MIPS_FETCH_STATS_EN adds counters.
module mips_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_instr,
    input  logic              out_ready
`ifdef MIPS_FETCH_STATS_EN
    ,
    output logic [15:0]       stat_flushes,
    output logic [15:0]       stat_stall_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      r_state, w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_next;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_stale, w_stale_next;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_accept, w_rsp, w_push, w_pop;
    logic [CNT_W-1:0]  w_count, w_count_next;
    fetch_entry_t      w_push_data, w_head;

    assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
    assign w_accept      = (r_state == REQ) && imem_req_ready;
    assign w_rsp         = (r_state == WAIT) && imem_rsp_valid;
    // Redirect wins over both a same-cycle response and a same-cycle pop.
    assign w_push        = w_rsp && !r_stale && !redirect_valid;
    assign w_pop         = out_valid && out_ready && !redirect_valid;
    assign w_count_next  = redirect_valid ? '0
                         : w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (redirect_valid || w_count < CNT_W'(DEPTH)) w_state_next = REQ;
            REQ:  if (imem_req_ready) w_state_next = WAIT;
            WAIT: if (imem_rsp_valid)
                      w_state_next = (w_count_next < CNT_W'(DEPTH)) ? REQ : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // fetch_pc is the next address to request; a stale request must not advance it.
    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (redirect_valid)
            w_fetch_pc_next = w_redirect_pc;
        else if (w_accept && !r_stale)
            w_fetch_pc_next = r_req_addr + ADDR_W'(PC_INCR);

        w_stale_next = r_stale;
        if (w_rsp)
            w_stale_next = 1'b0;
        else if (redirect_valid && r_state != IDLE)
            w_stale_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_stale    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_stale    <= w_stale_next;
            // Address is latched on REQ entry and held until accepted.
            if (w_state_next == REQ && r_state != REQ) r_req_addr <= w_fetch_pc_next;
        end
    end

    assign imem_req_valid = (r_state == REQ);
    assign imem_req_addr  = r_req_addr;

    assign w_push_data.pc    = ENTRY_PC_W'(r_req_addr);
    assign w_push_data.instr = imem_rsp_data;

    mips_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_pc    = ADDR_W'(w_head.pc);
    assign out_instr = w_head.instr;

`ifdef MIPS_FETCH_STATS_EN
    logic [15:0] r_stat_flushes, r_stat_stalls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_flushes <= '0;
            r_stat_stalls  <= '0;
        end else begin
            if (redirect_valid && r_stat_flushes != 16'hFFFF)
                r_stat_flushes <= r_stat_flushes + 16'd1;
            if (out_ready && !out_valid && r_stat_stalls != 16'hFFFF)
                r_stat_stalls <= r_stat_stalls + 16'd1;
        end
    end

    assign stat_flushes      = r_stat_flushes;
    assign stat_stall_cycles = r_stat_stalls;
`endif

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: random memory/core/redirect stimulus against a
// queue-level model, plus directed scenarios with literal expectations.
module tb_mips_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
`ifdef MIPS_FETCH_STATS_EN
    logic [15:0] stat_flushes, stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    mips_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
`ifdef MIPS_FETCH_STATS_EN
        ,
        .stat_flushes      (stat_flushes),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Stimulus knobs and directed hooks
    int          p_ready = 100, p_oready = 100, p_redir = 0, lat_lo = 1, lat_hi = 1;
    bit          dir_redir = 0, redir_on_rsp = 0;
    logic [31:0] dir_pc = '0, ros_pc = '0;
    bit          mem_new = 0, mem_busy = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;

    // Queue-level reference model
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_exp_pc = RESET_PC;
    int          m_epoch = 0, m_req_epoch = 0, m_if_epoch = 0;
    bit          m_inflight = 0, m_req_pend = 0;
    logic [31:0] m_req_addr = '0, m_if_addr = '0;
    int          gap = 0;
    int          m_flushes = 0, m_stalls = 0;
    logic [31:0] cap_pc[$], cap_in[$], acc_cap[$];

    // Memory and core driver: inputs change 1ns after the rising edge.
    initial begin : driver
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                if (mem_new) begin
                    mem_busy = 1;
                    mem_wait = $urandom_range(lat_hi, lat_lo);
                    mem_new  = 0;
                end
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
                if (mem_busy) begin
                    mem_wait--;
                    if (mem_wait == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(mem_addr);
                        mem_busy       = 0;
                    end
                end
                imem_req_ready = (int'($urandom_range(99, 0)) < p_ready);
                out_ready      = (int'($urandom_range(99, 0)) < p_oready);
                redirect_valid = (int'($urandom_range(99, 0)) < p_redir);
                redirect_pc    = $urandom;
                if (dir_redir) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = dir_pc;
                    dir_redir      = 0;
                end
                if (redir_on_rsp && imem_rsp_valid) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = ros_pc;
                    out_ready      = 1'b1;
                    redir_on_rsp   = 0;
                end
            end
        end
    end

    // Compare-and-advance on the falling edge, where all signals are settled.
    always @(negedge clk) begin : monitor
        int sz;
        if (!rst_n) begin
            chk("rst_req_valid", imem_req_valid, 1'b0);
            chk("rst_req_addr", imem_req_addr, RESET_PC);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_pc", out_pc, 32'h0);
            chk("rst_out_instr", out_instr, 32'h0);
`ifdef MIPS_FETCH_STATS_EN
            chk("rst_stat_flushes", 32'(stat_flushes), 32'h0);
            chk("rst_stat_stalls", 32'(stat_stall_cycles), 32'h0);
`endif
            m_q.delete();
            m_exp_pc = RESET_PC; m_epoch = 0; m_inflight = 0; m_req_pend = 0;
            gap = 0; m_flushes = 0; m_stalls = 0;
            cap_pc.delete(); cap_in.delete(); acc_cap.delete();
        end else begin
            sz = m_q.size();
            chk("out_valid", out_valid, sz != 0);
            if (sz != 0) begin
                chk("out_pc", out_pc, m_q[0].pc);
                chk("out_instr", out_instr, m_q[0].instr);
            end
`ifdef MIPS_FETCH_STATS_EN
            chk("stat_flushes", 32'(stat_flushes), 32'(m_flushes));
            chk("stat_stalls", 32'(stat_stall_cycles), 32'(m_stalls));
`endif
            if (m_req_pend) begin
                chk("req_hold", imem_req_valid, 1'b1);
                chk("req_addr_hold", imem_req_addr, m_req_addr);
            end else if (imem_req_valid) begin
                chk("req_addr", imem_req_addr, m_exp_pc);
                chk("req_room", sz < DEPTH, 1'b1);
                chk("req_single", m_inflight, 1'b0);
                m_req_addr  = imem_req_addr;
                m_req_epoch = m_epoch;
            end
            if (!imem_req_valid && !m_inflight && sz < DEPTH) gap++;
            else gap = 0;
            chk("fetch_live", gap <= 1, 1'b1);

            if (out_ready && sz == 0 && m_stalls < 65535) m_stalls++;
            if (redirect_valid && m_flushes < 65535) m_flushes++;
            if (sz != 0 && out_ready && !redirect_valid) begin
                cap_pc.push_back(m_q[0].pc);
                cap_in.push_back(m_q[0].instr);
                void'(m_q.pop_front());
            end
            if (imem_rsp_valid && m_inflight) begin
                if (m_if_epoch == m_epoch && !redirect_valid)
                    m_q.push_back('{pc: m_if_addr, instr: imem_rsp_data});
                m_inflight = 0;
            end
            if (imem_req_valid && imem_req_ready) begin
                m_inflight = 1;
                m_if_addr  = imem_req_addr;
                m_if_epoch = m_req_epoch;
                if (m_req_epoch == m_epoch) m_exp_pc = imem_req_addr + 32'd4;
                mem_addr = imem_req_addr;
                mem_new  = 1;
                acc_cap.push_back(imem_req_addr);
            end
            m_req_pend = imem_req_valid && !imem_req_ready;
            if (redirect_valid) begin
                m_q.delete();
                m_epoch++;
                m_exp_pc = redirect_pc & ~32'h3;
                cap_pc.delete(); cap_in.delete(); acc_cap.delete();
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        mem_new = 0; mem_busy = 0; dir_redir = 0; redir_on_rsp = 0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0; imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic knobs(input int rdy, input int ordy, input int rdr, input int lo, input int hi);
        p_ready = rdy; p_oready = ordy; p_redir = rdr; lat_lo = lo; lat_hi = hi;
    endtask

    task automatic chk_cap(input string nm, input int i, input logic [31:0] exp_pc);
        chk({nm, "_popped"}, cap_pc.size() > i, 1'b1);
        if (cap_pc.size() > i) begin
            chk({nm, "_pc"}, cap_pc[i], exp_pc);
            chk({nm, "_instr"}, cap_in[i], mem_word(exp_pc));
        end
    endtask

    initial begin : main
        bit ok;

        // Streaming: ready always, latency 1, core always ready
        knobs(100, 100, 0, 1, 1);
        do_reset();
        tick(1);
        chk("t1_first_idle", imem_req_valid, 1'b0);
        tick(1);
        chk("t1_first_req", imem_req_valid, 1'b1);
        chk("t1_first_addr", imem_req_addr, 32'h0);
        tick(12);
        for (int i = 0; i < 4; i++) chk_cap("t1", i, 32'(i * 4));

        // Back-pressure: exactly DEPTH entries buffered, then drain and resume at 16
        knobs(100, 0, 0, 1, 1);
        do_reset();
        tick(20);
        chk("t2_req_idle", imem_req_valid, 1'b0);
        chk("t2_out_valid", out_valid, 1'b1);
        chk("t2_head_pc", out_pc, 32'h0);
        chk("t2_fetched", acc_cap.size(), 32'd4);
        p_oready = 100;
        tick(12);
        for (int i = 0; i < 4; i++) chk_cap("t2", i, 32'(i * 4));
        chk("t2_resume_seen", acc_cap.size() > 4, 1'b1);
        if (acc_cap.size() > 4) chk("t2_resume_addr", acc_cap[4], 32'h10);

        // Redirect while waiting on the response for pc 8
        knobs(100, 100, 0, 3, 3);
        do_reset();
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick(1);
            ok = (acc_cap.size() == 3);
        end
        chk("t3_reach8", ok, 1'b1);
        if (ok) chk("t3_acc8", acc_cap[2], 32'h8);
        dir_pc = 32'h100; dir_redir = 1;
        tick(30);
        chk_cap("t3_a", 0, 32'h100);
        chk_cap("t3_b", 1, 32'h104);

        // Redirect from idle with unaligned target
        knobs(100, 0, 0, 1, 1);
        do_reset();
        tick(20);
        dir_pc = 32'h203; dir_redir = 1;
        tick(2);
        chk("t4_req_valid", imem_req_valid, 1'b1);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        chk("t4_out_valid", out_valid, 1'b0);

        // Redirect coincident with response and pop
        knobs(100, 0, 0, 4, 4);
        do_reset();
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick(1);
            ok = (m_q.size() == 3) && m_inflight;
        end
        chk("t5_setup", ok, 1'b1);
        ros_pc = 32'h400; redir_on_rsp = 1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick(1);
            ok = !redir_on_rsp;
        end
        chk("t5_fired", ok, 1'b1);
        chk("t5_was_full_path", out_valid, 1'b1);
        tick(1);
        chk("t5_flushed", out_valid, 1'b0);
        p_oready = 100;
        tick(20);
        chk_cap("t5", 0, 32'h400);

`ifdef MIPS_FETCH_STATS_EN
        // Five starved cycles, then three redirects
        knobs(0, 0, 0, 1, 1);
        do_reset();
        tick(1);
        p_oready = 100;
        tick(5);
        p_oready = 0;
        for (int i = 0; i < 3; i++) begin
            dir_pc = $urandom; dir_redir = 1;
            tick(2);
        end
        tick(1);
        chk("t6_flushes", 32'(stat_flushes), 32'd3);
        chk("t6_stalls", 32'(stat_stall_cycles), 32'd5);
`endif

        // Randomized traffic with one mid-run reset
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            knobs($urandom_range(100, 20), $urandom_range(100, 0), $urandom_range(8, 0),
                  1, $urandom_range(4, 1));
            if (blk == 4) begin
                tick(3);
                do_reset();
            end
            tick(500);
        end

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_fetch_queue.md
# mips_fetch_queue

Instruction-fetch front end for the MIPS core: generates sequential word-aligned fetch addresses, issues them to an instruction memory over a valid/ready request channel and a fixed-order response channel, and buffers returned (pc, instruction) pairs in a small queue. The queue feeds the core's decode/execute stage over a valid/ready interface. A redirect port, driven by the core's branch/jump/jr resolution, flushes the queue and restarts fetch at a new target.

## Interface
- `DEPTH`, 4: queue entries, power of two, ≥2.
- `ADDR_W`, 32: PC and memory address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; low 2 bits must be 0.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  ADDR_W  new fetch address; bits [1:0] ignored (forced 0).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  ADDR_W  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_rsp_valid`  in  1  response data valid; one per accepted request, in order.
- `imem_rsp_data`  in  32  instruction word.
- `out_valid`  out  1  head entry valid.
- `out_pc`  out  ADDR_W  PC of head instruction.
- `out_instr`  out  32  head instruction.
- `out_ready`  in  1  core consumes head this cycle.

## Operation
- Fetch FSM states: IDLE (no request), REQ (`imem_req_valid`=1, awaiting ready), WAIT (accepted, awaiting response). At most one request in flight.
- IDLE→REQ when `count + 0 < DEPTH` (free slot). REQ→WAIT on `imem_req_ready`; `fetch_pc += 4` on acceptance (wraps modulo 2^ADDR_W). WAIT→REQ on response if a slot remains after the push, else WAIT→IDLE.
- Request address and valid are stable while in REQ; a redirect never retracts a pending request.
- `stale` flag: set by redirect while in REQ or WAIT; a response arriving with `stale`=1 is discarded and clears `stale`. Redirect in REQ: the in-flight request completes, then fetch resumes from `redirect_pc`.
- Non-stale response pushes {`fetch_pc` of that request, `imem_rsp_data`} into the queue.
- Redirect: queue emptied, `fetch_pc` ← `redirect_pc & ~3`, same edge. Redirect beats simultaneous `out_ready` pop and simultaneous non-stale response (response dropped).
- Pop when `out_valid && out_ready`; push and pop in same cycle legal at any count, including full.
- `out_*` driven from queue head; `out_pc`/`out_instr` are don't-care when `out_valid`=0.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `out_valid`=0, `out_pc`=0, `out_instr`=0, count=0, `stale`=0, state IDLE.
- First cycle after `rst_n` deasserts: IDLE; `imem_req_valid` rises at the next edge.
- Response in cycle N → `out_valid` high in cycle N+1 (registered queue, no bypass).
- Redirect in cycle N → `out_valid`=0 in N+1; first request for `redirect_pc` valid in N+1 if idle, else after the stale response drains.
- Reset assertion mid-transaction: all state cleared immediately; memory must also be reset.
- Sustained throughput: one instruction per (memory latency + 1) cycles.

## Configuration
- `MIPS_FETCH_STATS_EN` defined: adds outputs `stat_flushes` (16 bit, redirect count) and `stat_stall_cycles` (16 bit, cycles with `out_ready`=1 and `out_valid`=0); both saturate at 16'hFFFF, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package `mips_fetch_pkg`: fetch state enum (IDLE, REQ, WAIT), `PC_INCR`=4, `fetch_entry_t` {pc, instr}.
- Sub-module `mips_fetch_fifo`: synchronous FIFO of `fetch_entry_t`, DEPTH entries, push/pop/flush, count output.

## Test plan
- Reset release, memory ready always, 1-cycle latency, `out_ready`=1 → `out_pc` sequence 0,4,8,12 with matching instructions.
- `out_ready`=0 → exactly DEPTH=4 entries buffered (pc 0..12), `imem_req_valid` stays 0; then `out_ready`=1 drains in order, fetch resumes at 16.
- Redirect to 0x100 while in WAIT for pc 8 → response for 8 dropped, next `out_pc`=0x100, no stale entry visible.
- Redirect to 0x203 → first request address 0x200.
- Redirect coincident with response and pop, queue full → queue empty next cycle, no pop of old data observed.
- `MIPS_FETCH_STATS_EN`: three redirects and 5 starved cycles → `stat_flushes`=3, `stat_stall_cycles`=5.
